recv_reg_axis: RTL and testbench

Serial-to-AXIS receiver for the two-wire LED bus (serial clock plus data, MSB first, 32-bit words, data valid on the serial clock rising edge). It is the counterpart of the bus shifter. It oversamples the external clock and data pins in the i_clk domain and assembles 32-bit words. Each completed word is presented on an AXI-Stream master port. It is used for loopback checking of the LED bar driver and for snooping or forwarding LED frames.

---
 rtl/recv_reg_axis.sv | 131 +++++++++++++
 tb/tb_recv_reg_axis.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/recv_reg_axis.sv
// Two-wire LED bus receiver: oversamples serial clock/data, emits 32-bit words on AXIS.
// Optional macro RECV_TIMEOUT_EN discards a partial word after TIMEOUT_CYCLES idle cycles.
module recv_reg_axis #(
    parameter int WORD_BITS      = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_led_clk,
    input  logic                 i_led_data,
    output logic [WORD_BITS-1:0] m_axis_data,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CW = $clog2(WORD_BITS);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sync_clk;
    logic                   sync_data;
    logic                   prev_clk;
    logic                   armed;
    logic                   rise;
    logic                   timeout;
    logic [WORD_BITS-1:0]   shift;
    logic [CW-1:0]          cnt;
    logic                   done;

    assign sync_clk  = clk_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];
    assign rise      = sync_clk & ~prev_clk & armed;
    assign o_busy    = (cnt != '0);

    // Equal-depth synchronizers; fill marks which stages hold real pin samples
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            clk_sync  <= '0;
            data_sync <= '0;
            fill      <= '0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_led_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], i_led_data};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Edge history; arm only once a genuine low level has been observed
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_clk <= 1'b0;
            armed    <= 1'b0;
        end else begin
            prev_clk <= sync_clk;
            if (fill[SYNC_STAGES-1] && !sync_clk)
                armed <= 1'b1;
        end
    end

`ifdef RECV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;

    assign timeout = o_busy && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Count idle cycles while a partial word is held
    always_ff @(posedge i_clk) begin
        if (i_reset || rise || !o_busy)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    // Shift in one bit per rise; flag the word complete on the last bit
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rise) begin
                if (timeout) begin
                    shift <= {{(WORD_BITS-1){1'b0}}, sync_data};
                    cnt   <= CW'(1);
                end else begin
                    shift <= {shift[WORD_BITS-2:0], sync_data};
                    if (cnt == CW'(WORD_BITS - 1)) begin
                        cnt  <= '0;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end else if (timeout) begin
                shift <= '0;
                cnt   <= '0;
            end
        end
    end

    // Single-entry output holder; a word arriving while stalled is dropped
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_axis_data   <= '0;
            m_axis_tvalid <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (done) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_data   <= shift;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_recv_reg_axis.sv
// Directed bench for recv_reg_axis: table of single words plus hand sequences.
// Honours RECV_TIMEOUT_EN when choosing the timeout expectation.
module tb_recv_reg_axis;

    localparam int HP = 16;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_led_clk = 1'b0;
    logic        i_led_data = 1'b0;
    logic [31:0] m_axis_data;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        o_overrun;
    logic        o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ovr_cnt = 0;
    int tv_cycles = 0;
    logic [31:0] beats[$];

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    recv_reg_axis #(
        .WORD_BITS(32),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_led_clk(i_led_clk),
        .i_led_data(i_led_data),
        .m_axis_data(m_axis_data),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .o_overrun(o_overrun),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Record accepted beats, overrun pulses and valid cycles away from the edge
    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (m_axis_tvalid && m_axis_tready)
                beats.push_back(m_axis_data);
            if (o_overrun)
                ovr_cnt++;
            if (m_axis_tvalid)
                tv_cycles++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_at(input int i);
        if (beats.size() > i)
            return beats[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        beats.delete();
        ovr_cnt = 0;
        tv_cycles = 0;
    endtask

    task automatic send_bit(input logic b);
        i_led_data = b;
        repeat (HP) @(posedge i_clk);
        #1 i_led_clk = 1'b1;
        repeat (HP) @(posedge i_clk);
        #1 i_led_clk = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++)
            send_bit(w[31-i]);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[2] = '{32'h8000_0001, 32'h8000_0001};
        vecs[3] = '{32'h5A3C_96E1, 32'h5A3C_96E1};
        vecs[4] = '{32'h0123_4567, 32'h0123_4567};

        do_reset();
        chk("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        chk("rst_data", m_axis_data, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_ovr", {31'b0, o_overrun}, 32'd0);

        // Test 1: exact latency and single-cycle beat
        m_axis_tready = 1'b1;
        send_word(32'hE0FF_0000, 31);
        i_led_data = 1'b0;
        repeat (HP) @(posedge i_clk);
        #1 i_led_clk = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 chk("t1_early", {31'b0, m_axis_tvalid}, 32'd0);
        @(posedge i_clk);
        #1 chk("t1_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
        chk("t1_data", m_axis_data, 32'hE0FF_0000);
        @(posedge i_clk);
        #1 chk("t1_drop", {31'b0, m_axis_tvalid}, 32'd0);
        repeat (HP - 5) @(posedge i_clk);
        #1 i_led_clk = 1'b0;
        repeat (HP) @(posedge i_clk);
        #1 chk("t1_beats", beats.size(), 32'd1);
        chk("t1_vcyc", tv_cycles, 32'd1);
        chk("t1_ovr", ovr_cnt, 32'd0);

        // Table of single words with tready high
        for (int i = 0; i < 5; i++) begin
            beats.delete();
            ovr_cnt = 0;
            send_word(vecs[i].word, 32);
            repeat (8) @(posedge i_clk);
            #1 chk($sformatf("vec%0d_cnt", i), beats.size(), 32'd1);
            chk($sformatf("vec%0d_data", i), beat_at(0), vecs[i].exp);
            chk($sformatf("vec%0d_ovr", i), ovr_cnt, 32'd0);
            chk($sformatf("vec%0d_busy", i), {31'b0, o_busy}, 32'd0);
        end

        // Test 2: stall, overrun on second word
        do_reset();
        m_axis_tready = 1'b0;
        send_word(32'h1234_5678, 32);
        repeat (8) @(posedge i_clk);
        #1 chk("t2_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
        chk("t2_data", m_axis_data, 32'h1234_5678);
        chk("t2_ovr0", ovr_cnt, 32'd0);
        send_word(32'hDEAD_BEEF, 32);
        repeat (8) @(posedge i_clk);
        #1 chk("t2_ovr1", ovr_cnt, 32'd1);
        chk("t2_hold", m_axis_data, 32'h1234_5678);
        m_axis_tready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1 chk("t2_beats", beats.size(), 32'd1);
        chk("t2_beat0", beat_at(0), 32'h1234_5678);
        chk("t2_idle", {31'b0, m_axis_tvalid}, 32'd0);

        // Test 3: accept and reload in the same cycle
        do_reset();
        m_axis_tready = 1'b0;
        send_word(32'h1111_1111, 32);
        repeat (8) @(posedge i_clk);
        send_word(32'hCAFE_F00D, 31);
        i_led_data = 1'b1;
        repeat (HP) @(posedge i_clk);
        #1 i_led_clk = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 m_axis_tready = 1'b1;
        @(posedge i_clk);
        #1 m_axis_tready = 1'b0;
        chk("t3_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
        chk("t3_data", m_axis_data, 32'hCAFE_F00D);
        chk("t3_ovr", ovr_cnt, 32'd0);
        chk("t3_beat0", beat_at(0), 32'h1111_1111);
        repeat (HP - 4) @(posedge i_clk);
        #1 i_led_clk = 1'b0;
        repeat (HP) @(posedge i_clk);
        #1 m_axis_tready = 1'b1;
        repeat (4) @(posedge i_clk);
        #1 chk("t3_beats", beats.size(), 32'd2);
        chk("t3_beat1", beat_at(1), 32'hCAFE_F00D);

        // Test 4: reset mid-word
        do_reset();
        send_word(32'hFFFF_FFFF, 10);
        chk("t4_busy", {31'b0, o_busy}, 32'd1);
        do_reset();
        chk("t4_busy_rst", {31'b0, o_busy}, 32'd0);
        send_word(32'hA5A5_A5A5, 32);
        repeat (8) @(posedge i_clk);
        #1 chk("t4_beats", beats.size(), 32'd1);
        chk("t4_data", beat_at(0), 32'hA5A5_A5A5);

        // Test 5: serial clock high across reset release
        i_led_clk = 1'b1;
        do_reset();
        repeat (20) @(posedge i_clk);
        #1 i_led_clk = 1'b0;
        repeat (HP) @(posedge i_clk);
        #1 chk("t5_nobit", {31'b0, o_busy}, 32'd0);
        send_word(32'h0000_0001, 32);
        repeat (8) @(posedge i_clk);
        #1 chk("t5_beats", beats.size(), 32'd1);
        chk("t5_data", beat_at(0), 32'h0000_0001);

        // Test 6: idle gap after a partial word
        do_reset();
        send_word(32'hFF00_0000, 8);
        repeat (100) @(posedge i_clk);
        #1;
        send_word(32'h0000_0001, 32);
        repeat (8) @(posedge i_clk);
        #1 chk("t6_beats", beats.size(), 32'd1);
`ifdef RECV_TIMEOUT_EN
        chk("t6_data", beat_at(0), 32'h0000_0001);
        chk("t6_busy", {31'b0, o_busy}, 32'd0);
`else
        chk("t6_data", beat_at(0), 32'hFF00_0000);
        chk("t6_busy", {31'b0, o_busy}, 32'd1);
`endif
        chk("t6_ovr", ovr_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
